// File: rtl/ddr_refresh_sequencer.sv
// ddr_refresh_sequencer
//   Issues the DDR4 refresh sequence on behalf of the controller FSM.
//   A one-cycle refresh_rdy pulse is queued in pending_cnt. Once the
//   read/write engine is idle, the sequencer drives PRECHARGE ALL (only when
//   a bank is open), waits tRP, drives REFRESH, waits tRFC, then pulses
//   ref_done.
//
// Optional feature macro: REF_POSTPONE_EN
//   Defined   : up to MAX_PENDING requests are queued. Back-to-back REFs
//               are issued from DONE without returning to IDLE.
//   Undefined : a single request can be queued. A second request while one
//               is pending sets overflow.
//
// Ports
//   clock_t      in   controller clock, all logic on posedge
//   reset        in   synchronous reset, active-high
//   refresh_rdy  in   one-cycle refresh request pulse
//   rw_idle      in   read/write engine quiescent (sampled in IDLE/DONE)
//   banks_open   in   at least one bank active (sampled in IDLE)
//   cs_n, act_n, ras_n, cas_n, we_n, a10
//                out  registered DDR4 command pins
//   busy         out  sequence in progress
//   ref_done     out  one-cycle pulse at end of tRFC
//   pending_cnt  out  outstanding refresh requests
//   overflow     out  sticky, a request was lost
module ddr_refresh_sequencer #(
    parameter int T_RP        = 12,
    parameter int T_RFC       = 260,
    parameter int MAX_PENDING = 8
) (
    input  logic       clock_t,
    input  logic       reset,
    input  logic       refresh_rdy,
    input  logic       rw_idle,
    input  logic       banks_open,
    output logic       cs_n,
    output logic       act_n,
    output logic       ras_n,
    output logic       cas_n,
    output logic       we_n,
    output logic       a10,
    output logic       busy,
    output logic       ref_done,
    output logic [3:0] pending_cnt,
    output logic       overflow
);

    localparam int TMAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int CW   = (($clog2(TMAX) + 1) > 9) ? ($clog2(TMAX) + 1) : 9;

`ifdef REF_POSTPONE_EN
    localparam logic [3:0] PEND_LIMIT = 4'(MAX_PENDING);
`else
    localparam logic [3:0] PEND_LIMIT = 4'd1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_RP,
        REF,
        WAIT_RFC,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          issue_ref;
    logic          has_pending;

    assign has_pending = (pending_cnt != '0);

    // The command pins are registered from state_next, so each command is
    // on the pins during the very cycle its state is occupied.
    assign issue_ref = (state_next == REF);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (has_pending && rw_idle) begin
                    state_next = banks_open ? PRE : REF;
                end
            end
            PRE: begin
                state_next = WAIT_RP;
                cnt_next   = CW'(T_RP - 2);
            end
            WAIT_RP: begin
                if (cnt == '0) begin
                    state_next = REF;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            REF: begin
                state_next = WAIT_RFC;
                cnt_next   = CW'(T_RFC - 2);
            end
            WAIT_RFC: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE: begin
`ifdef REF_POSTPONE_EN
                // Banks were closed by the previous sequence, so chain
                // straight into the next REF without a PREA.
                state_next = (has_pending && rw_idle) ? REF : IDLE;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_t) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cs_n        <= 1'b1;
            act_n       <= 1'b1;
            ras_n       <= 1'b1;
            cas_n       <= 1'b1;
            we_n        <= 1'b1;
            a10         <= 1'b0;
            busy        <= 1'b0;
            ref_done    <= 1'b0;
            pending_cnt <= '0;
            overflow    <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            cs_n     <= !((state_next == PRE) || (state_next == REF));
            act_n    <= 1'b1;
            ras_n    <= !((state_next == PRE) || (state_next == REF));
            cas_n    <= !(state_next == REF);
            we_n     <= !(state_next == PRE);
            a10      <= (state_next == PRE);
            busy     <= (state_next != IDLE);
            ref_done <= (state_next == DONE);

            // A capture and a REF issue on the same edge cancel out, so
            // nothing is lost even when the queue is full.
            if (refresh_rdy && !issue_ref) begin
                if (pending_cnt >= PEND_LIMIT) begin
                    overflow <= 1'b1;
                end else begin
                    pending_cnt <= pending_cnt + 1'b1;
                end
            end else if (issue_ref && !refresh_rdy && has_pending) begin
                pending_cnt <= pending_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_refresh_sequencer.sv
// Directed testbench for ddr_refresh_sequencer. A cycle counter and a
// negedge monitor record when each command, ref_done pulse and busy edge
// occurs. Each scenario is then checked against hand-computed cycle
// numbers. The postponed-burst scenario runs only when REF_POSTPONE_EN is
// defined. The overflow scenario runs only when it is not defined.
module tb_ddr_refresh_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       refresh_rdy = 1'b0;
    logic       rw_idle = 1'b1;
    logic       banks_open = 1'b0;
    logic       cs_n, act_n, ras_n, cas_n, we_n, a10;
    logic       busy, ref_done, overflow;
    logic [3:0] pending_cnt;

    localparam logic [5:0] PINS_NOP  = 6'b111110;
    localparam logic [5:0] PINS_PREA = 6'b010101;
    localparam logic [5:0] PINS_REF  = 6'b010010;

    ddr_refresh_sequencer #(.T_RP(12), .T_RFC(260), .MAX_PENDING(8)) dut (
        .clock_t     (clk),
        .reset       (reset),
        .refresh_rdy (refresh_rdy),
        .rw_idle     (rw_idle),
        .banks_open  (banks_open),
        .cs_n        (cs_n),
        .act_n       (act_n),
        .ras_n       (ras_n),
        .cas_n       (cas_n),
        .we_n        (we_n),
        .a10         (a10),
        .busy        (busy),
        .ref_done    (ref_done),
        .pending_cnt (pending_cnt),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    logic [5:0] pins;
    assign pins = {cs_n, act_n, ras_n, cas_n, we_n, a10};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_prea = 0, n_ref = 0, n_done = 0;
    int last_prea = -1, last_ref = -1, last_done = -1;
    int busy_rise = -1, busy_last = -1;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (pins == PINS_PREA) begin
            n_prea++;
            last_prea = cyc;
        end
        if (pins == PINS_REF) begin
            n_ref++;
            last_ref = cyc;
        end
        if (ref_done) begin
            n_done++;
            last_done = cyc;
        end
        if (busy && !prev_busy) busy_rise = cyc;
        if (busy) busy_last = cyc;
        prev_busy = busy;
    end

    int n_vec = 0;
    int n_miscompare = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_req();
        refresh_rdy = 1'b1;
        tick();
        refresh_rdy = 1'b0;
    endtask

    int c0, c1, b_prea, b_ref, b_done;

    task automatic snap();
        b_prea = n_prea;
        b_ref  = n_ref;
        b_done = n_done;
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_pins", int'(pins), int'(PINS_NOP));
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(ref_done), 0);
        check("rst_pend", int'(pending_cnt), 0);
        check("rst_ovf", int'(overflow), 0);
        reset = 1'b0;
        tick(5);

        // 1: banks closed, REF two cycles after the request pulse
        rw_idle = 1'b1; banks_open = 1'b0;
        snap();
        c0 = cyc;
        pulse_req();
        check("t1_pend", int'(pending_cnt), 1);
        tick();
        check("t1_ref_pins", int'(pins), int'(PINS_REF));
        tick(280);
        check("t1_ref_cyc", last_ref, c0 + 2);
        check("t1_nref", n_ref - b_ref, 1);
        check("t1_nprea", n_prea - b_prea, 0);
        check("t1_done_cyc", last_done, c0 + 262);
        check("t1_ndone", n_done - b_done, 1);
        check("t1_busy_rise", busy_rise, c0 + 2);
        check("t1_busy_last", busy_last, c0 + 262);
        check("t1_pend_end", int'(pending_cnt), 0);

        // 2: banks open, PREA then REF tRP later
        banks_open = 1'b1;
        snap();
        c0 = cyc;
        pulse_req();
        tick();
        check("t2_prea_pins", int'(pins), int'(PINS_PREA));
        tick(290);
        check("t2_prea_cyc", last_prea, c0 + 2);
        check("t2_nprea", n_prea - b_prea, 1);
        check("t2_ref_cyc", last_ref, c0 + 14);
        check("t2_done_cyc", last_done, c0 + 274);
        check("t2_ndone", n_done - b_done, 1);

        // 3: request blocked while rw_idle is low
        rw_idle = 1'b0; banks_open = 1'b0;
        snap();
        pulse_req();
        tick(49);
        check("t3_pend", int'(pending_cnt), 1);
        check("t3_busy", int'(busy), 0);
        check("t3_pins", int'(pins), int'(PINS_NOP));
        check("t3_nref", n_ref - b_ref, 0);
        c1 = cyc;
        rw_idle = 1'b1;
        tick();
        check("t3_ref_pins", int'(pins), int'(PINS_REF));
        tick(270);
        check("t3_ref_cyc", last_ref, c1 + 1);
        check("t3_ndone", n_done - b_done, 1);

`ifndef REF_POSTPONE_EN
        // 4: second request while one is pending is lost
        rw_idle = 1'b0;
        snap();
        pulse_req();
        tick(4);
        pulse_req();
        tick();
        check("t4_pend", int'(pending_cnt), 1);
        check("t4_ovf", int'(overflow), 1);
        rw_idle = 1'b1;
        tick(280);
        check("t4_ndone", n_done - b_done, 1);
        check("t4_pend_end", int'(pending_cnt), 0);
        check("t4_ovf_sticky", int'(overflow), 1);
`else
        // 5: postponed burst, one PREA then chained REFs
        rw_idle = 1'b0; banks_open = 1'b1;
        snap();
        pulse_req();
        tick();
        pulse_req();
        tick();
        pulse_req();
        check("t5_pend", int'(pending_cnt), 3);
        c1 = cyc;
        rw_idle = 1'b1;
        tick(900);
        check("t5_prea_cyc", last_prea, c1 + 1);
        check("t5_nprea", n_prea - b_prea, 1);
        check("t5_nref", n_ref - b_ref, 3);
        check("t5_last_ref", last_ref, c1 + 13 + 2 * 261);
        check("t5_ndone", n_done - b_done, 3);
        check("t5_last_done", last_done, c1 + 13 + 2 * 261 + 260);
        check("t5_busy_rise", busy_rise, c1 + 1);
        check("t5_busy_last", busy_last, c1 + 13 + 2 * 261 + 260);
        check("t5_pend_end", int'(pending_cnt), 0);
`endif

        // 6: reset during WAIT_RFC abandons the sequence
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rw_idle = 1'b1; banks_open = 1'b0;
        tick(3);
        snap();
        c0 = cyc;
        pulse_req();
        tick(101);
        reset = 1'b1;
        tick();
        check("t6_busy", int'(busy), 0);
        check("t6_pend", int'(pending_cnt), 0);
        check("t6_pins", int'(pins), int'(PINS_NOP));
        check("t6_ovf", int'(overflow), 0);
        reset = 1'b0;
        tick(300);
        check("t6_ref_cyc", last_ref, c0 + 2);
        check("t6_nref", n_ref - b_ref, 1);
        check("t6_ndone", n_done - b_done, 0);
        check("t6_busy_end", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
